// File: rtl/serial_rx_pkg.sv
// Shared types and line levels for the framed serial word receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/rx_shift_reg.sv
// Directional serial-in shift register; mirror of the transmitting shift register.
module rx_shift_reg
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // dir=1 fills from the LSB end (MSB arrives first), dir=0 fills from the MSB end.
  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = dir ? {q_q[WIDTH-2:0], ser_in} : {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial receiver: start, WIDTH data bits, even parity, stop; one-word output buffer.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             ser_in,
  input  logic             ser_en,
  input  logic             msb_first,
  output logic [WIDTH-1:0] A_par,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             parity_err,
  output logic             framing_err,
  output logic             overrun
);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             rx_par_q;
  logic [WIDTH-1:0] a_par_q;
  logic             par_valid_q;
  logic             parity_err_q;
  logic             framing_err_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shreg;
  logic             shift_en;
  logic             consume;
  logic             last_bit;
  logic             frame_perr;

  assign shift_en   = ser_en && (state_q == StData);
  assign consume    = par_valid_q & par_ready;
  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  assign frame_perr = ((^shreg) ^ rx_par_q) != PARITY_EVEN;

  rx_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .CLK     (CLK),
    .Clear   (Clear),
    .shift_en(shift_en),
    .dir     (dir_q),
    .ser_in  (ser_in),
    .q       (shreg)
  );

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      rx_par_q      <= 1'b0;
      a_par_q       <= '0;
      par_valid_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      if (consume) begin
        par_valid_q <= 1'b0;
      end
      if (ser_en) begin
        unique case (state_q)
          StIdle: begin
            if (ser_in == START_LEVEL) begin
              state_q <= StData;
              cnt_q   <= '0;
              dir_q   <= msb_first;
            end
          end
          StData: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            rx_par_q <= ser_in;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (ser_in == STOP_LEVEL) begin
              // A same-edge consume frees the buffer for the incoming word.
              if (!par_valid_q || consume) begin
                a_par_q      <= shreg;
                parity_err_q <= frame_perr;
                par_valid_q  <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_err_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign A_par       = a_par_q;
  assign par_valid   = par_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed frame table plus randomized frames against a model.
module tb_serial_word_receiver;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Clear;
  logic             ser_in;
  logic             ser_en;
  logic             msb_first;
  logic [WIDTH-1:0] A_par;
  logic             par_valid;
  logic             par_ready;
  logic             parity_err;
  logic             framing_err;
  logic             overrun;

  int tests = 0;
  int fails = 0;

  logic             model_chk = 1'b0;
  logic [WIDTH-1:0] m_a;
  logic             m_valid, m_perr, m_ferr, m_ovr;

  always #5 CLK = ~CLK;

  serial_word_receiver #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .msb_first  (msb_first),
    .A_par      (A_par),
    .par_valid  (par_valid),
    .par_ready  (par_ready),
    .parity_err (parity_err),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  typedef struct {
    logic [WIDTH-1:0] w;
    logic             msb;
    logic             pbit;
    logic             sbit;
    int               gaps;
    logic             rdy_stop;
    logic             drain;
    logic [WIDTH-1:0] ea;
    logic             ev;
    logic             epe;
    logic             efe;
    logic             eov;
  } vec_t;

  vec_t vecs [7];

  // strict=1 compares A_par/parity_err even when no word is expected.
  task automatic check_outs(input string name, input logic [WIDTH-1:0] ea, input logic ev,
                            input logic epe, input logic efe, input logic eov,
                            input logic strict);
    logic ok;
    tests++;
    ok = (par_valid === ev) && (framing_err === efe) && (overrun === eov);
    if (ev || strict) ok = ok && (A_par === ea) && (parity_err === epe);
    if (!ok) begin
      fails++;
      $display("FAIL %s: got A_par=%b valid=%b perr=%b ferr=%b ovr=%b, want A_par=%b valid=%b perr=%b ferr=%b ovr=%b",
               name, A_par, par_valid, parity_err, framing_err, overrun, ea, ev, epe, efe, eov);
    end
  endtask

  // kind: 0 ordinary edge, 1 good stop edge, 2 bad stop edge.
  task automatic step(input logic sin, input logic en, input logic rdy, input int kind,
                      input logic [WIDTH-1:0] w, input logic pe);
    ser_in    = sin;
    ser_en    = en;
    par_ready = rdy;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (!Clear) begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (en && kind == 1) begin
        if (!m_valid) begin
          m_a     = w;
          m_perr  = pe;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (en && kind == 2) m_ferr = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (model_chk) check_outs("model", m_a, m_valid, m_perr, m_ferr, m_ovr, 1'b0);
  endtask

  function automatic logic pick_rdy(input int mode, input logic is_stop);
    if (mode == 1) return is_stop;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // gaps: 0 none, 1 one ser_en=0 edge before each bit, 2 random 0..2.
  // rmode: 0 ready low, 1 ready only on stop edge, 2 random every edge.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic msb, input logic pbit,
                            input logic sbit, input int gaps, input int rmode);
    logic bits [WIDTH+3];
    logic pe;
    int   kind;
    int   ng;
    pe      = (^w) ^ pbit;
    bits[0] = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) bits[i+1] = msb ? w[WIDTH-1-i] : w[i];
    bits[WIDTH+1] = pbit;
    bits[WIDTH+2] = sbit;
    msb_first = msb;
    for (int b = 0; b < int'(WIDTH) + 3; b++) begin
      ng = (gaps == 0) ? 0 : (gaps == 1) ? 1 : $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) step(~bits[b], 1'b0, pick_rdy(rmode, 1'b0), 0, w, pe);
      kind = (b == int'(WIDTH) + 2) ? (sbit ? 1 : 2) : 0;
      step(bits[b], 1'b1, pick_rdy(rmode, b == int'(WIDTH) + 2), kind, w, pe);
      // Direction must stay latched from the start bit.
      if (b == 0) msb_first = ~msb;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rw;
    logic             rmsb, rpbit, rsbit;

    Clear = 1'b1; ser_in = 1'b1; ser_en = 1'b0; msb_first = 1'b0; par_ready = 1'b0;
    m_a = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    //   w       msb   pbit  sbit  gaps rdy   drain  ea      ev    epe   efe   eov
    vecs[0] = '{3'b101, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b110, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'b101, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'b010, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'b011, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{3'b100, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'b111, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0};

    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    Clear = 1'b0;

    // Start a frame, then clear it mid-DATA for two cycles.
    msb_first = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    Clear = 1'b1;
    step(1'b0, 1'b1, 1'b1, 0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 0, '0, 1'b0);
    check_outs("mid_frame_clear", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    Clear = 1'b0;
    step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
    check_outs("idle_after_clear", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].w, vecs[k].msb, vecs[k].pbit, vecs[k].sbit, vecs[k].gaps,
                 vecs[k].rdy_stop ? 1 : 0);
      check_outs($sformatf("vec%0d_stop", k), vecs[k].ea, vecs[k].ev, vecs[k].epe,
                 vecs[k].efe, vecs[k].eov, 1'b0);
      step(1'b1, 1'b1, vecs[k].drain, 0, '0, 1'b0);
      check_outs($sformatf("vec%0d_after", k), vecs[k].ea, vecs[k].ev && !vecs[k].drain,
                 vecs[k].epe, 1'b0, 1'b0, 1'b0);
    end

    model_chk = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0, 1'b0);
      end
      rw    = WIDTH'($urandom);
      rmsb  = 1'($urandom_range(0, 1));
      rpbit = (^rw) ^ ($urandom_range(0, 3) == 0);
      rsbit = ($urandom_range(0, 4) != 0);
      send_frame(rw, rmsb, rpbit, rsbit, 2, 2);
    end
    for (int d = 0; d < 3; d++) step(1'b1, 1'b1, 1'b1, 0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receiving end of the serial link driven by the team's universal shift register when it runs in shift-left/shift-right mode.
- Samples a framed serial bit stream: start bit, WIDTH data bits, even parity, stop bit.
- Rebuilds the parallel word in the order set by a direction input, buffers one word and presents it through a valid/ready handshake.
- Reports parity, framing and overrun errors.

Parameters:
- WIDTH, 3, data bits per frame (legal range 2..16).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Clear  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data line; idle level is 1.
- ser_en  input  1  bit strobe; ser_in is sampled only on edges where ser_en=1.
- msb_first  input  1  1: first data bit is the word MSB (shift-left source). 0: first data bit is the LSB (shift-right source). Sampled at start-bit acceptance and held for the frame.
- A_par  output  WIDTH  received word (output buffer).
- par_valid  output  1  A_par holds an unconsumed word.
- par_ready  input  1  consumer accepts A_par when par_valid & par_ready.
- parity_err  output  1  parity status of the word in A_par; valid while par_valid=1.
- framing_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Clear=1 at any edge, including mid-frame:
  - A_par=0, par_valid=0, parity_err=0, framing_err=0, overrun=0.
  - state=IDLE, bit counter=0, shift register=0.
  - Clear overrides all other inputs.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with ser_en=1; with ser_en=0 the FSM holds state.
  - IDLE: ser_in=0 goes to DATA (latch msb_first, counter=0). ser_in=1 stays in IDLE.
  - DATA: shift ser_in into the assembly register and increment the counter. After the WIDTH-th bit (counter=WIDTH-1), go to PARITY.
  - PARITY: store ser_in as rx_par. Go to STOP.
  - STOP, ser_in=1: frame good; deliver the word (see below). Go to IDLE.
  - STOP, ser_in=0: pulse framing_err for one cycle; discard the word; no delivery. Go to IDLE.
- Assembly:
  - msb_first=1: reg <= {reg[WIDTH-2:0], ser_in}.
  - msb_first=0: reg <= {ser_in, reg[WIDTH-1:1]}.
  - After WIDTH bits the register holds the transmitted word unchanged.
- Parity: even parity, so the XOR of all data bits and rx_par must be 0. If nonzero, parity_err=1 is loaded along with the word. The word is still delivered.
- Delivery (on the good-stop edge):
  - Buffer free (par_valid=0), or buffer consumed this same edge (par_valid & par_ready): load A_par and parity_err, set par_valid=1.
  - Latency: par_valid is visible the cycle after the edge that samples the stop bit.
  - Buffer full and not consumed this edge: keep the old A_par and parity_err, drop the new word, pulse overrun for one cycle.
- Handshake:
  - par_valid stays high, and A_par and parity_err stay stable, until a par_valid & par_ready edge.
  - On that edge par_valid clears, unless a new word loads on the same edge, in which case it stays 1.
- A start bit may be accepted on the edge right after the STOP edge; there is no minimum idle gap.
- framing_err and overrun are registered pulses, low on every other cycle.

Decomposition:
- Package serial_rx_pkg holds:
  - state typedef (IDLE, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1, PARITY_EVEN=1'b0.
- Sub-module rx_shift_reg (WIDTH): directional serial-in shift register.
  - Inputs: CLK, Clear, shift_en, dir, ser_in.
  - Output: q.
  - It is the structural mirror of the transmitting shift register.
- The top level holds the FSM, bit counter, parity, and output buffer with its flags.

Test Plan:
- Reset:
  - Clear=1 for 2 cycles mid-DATA -> all outputs 0, FSM returns to IDLE.
  - A following full frame then receives correctly.
- MSB-first, WIDTH=3, ser_en=1 every cycle, par_ready=0:
  - bits 0,1,0,1,0,1 -> A_par=3'b101, parity_err=0.
  - par_valid=1 one cycle after the stop edge and held until par_ready=1.
- LSB-first with gaps (msb_first=0, ser_en toggling 1/0):
  - bits 0,0,1,1,0,1 -> A_par=3'b110, parity_err=0.
  - The FSM holds during ser_en=0 cycles.
- Parity and framing:
  - frame for 3'b101 with parity bit 1 -> A_par=3'b101, parity_err=1.
  - next frame with stop bit 0 -> framing_err one-cycle pulse, par_valid unchanged.
- Overrun and concurrent consume (par_ready=0):
  - send 3'b011, then 3'b100 -> A_par stays 3'b011, overrun pulses once.
  - then send 3'b111 with par_ready=1 on its stop edge -> A_par=3'b111, par_valid stays 1, no overrun.
